sopc_run_ctrl: RTL and testbench

//  Parametrised run controller for the min-SOPC: stretches the incoming reset

---
 rtl/sopc_run_ctrl.sv | 124 ++++++++++++
 tb/tb_sopc_run_ctrl.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/sopc_run_ctrl.sv
// Run controller for the min-SOPC: stretched CPU reset, run-cycle counter,
// end-of-test store detector and watchdog. Optional restart: SOPC_RUN_CTRL_RESTART_EN.
module sopc_run_ctrl #(
    parameter int unsigned       RST_CYCLES     = 10,
    parameter int unsigned       TIMEOUT_CYCLES = 1000,
    parameter int unsigned       ADDR_W         = 32,
    parameter int unsigned       DATA_W         = 32,
    parameter logic [ADDR_W-1:0] DONE_ADDR      = ADDR_W'(32'h0000_FFF0),
    parameter logic [DATA_W-1:0] PASS_CODE      = DATA_W'(32'h600D_600D)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mon_we,
    input  logic [ADDR_W-1:0] mon_addr,
    input  logic [DATA_W-1:0] mon_data,
    input  logic              restart,
    output logic              cpu_rst,
    output logic              running,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [31:0]       cycle_cnt,
    output logic [DATA_W-1:0] result
);

    localparam int unsigned RST_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_CYCLES - 1);
    localparam logic [31:0]      CNT_LAST = 32'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] ST_RESET   = 2'd0;
    localparam logic [1:0] ST_RUN     = 2'd1;
    localparam logic [1:0] ST_DONE    = 2'd2;
    localparam logic [1:0] ST_TIMEOUT = 2'd3;

    logic [1:0]        state, state_nxt;
    logic [RST_W-1:0]  rst_cnt, rst_cnt_nxt;
    logic [31:0]       cnt_nxt;
    logic              done_nxt, pass_nxt, timeout_nxt;
    logic [DATA_W-1:0] result_nxt;
    logic              store_hit;

    assign store_hit = mon_we && (mon_addr == DONE_ADDR);

`ifndef SOPC_RUN_CTRL_RESTART_EN
    logic unused_restart;
    assign unused_restart = restart;
`endif

    // State register and registered outputs; rst overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_RESET;
            rst_cnt   <= '0;
            cpu_rst   <= 1'b1;
            running   <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            timeout   <= 1'b0;
            cycle_cnt <= '0;
            result    <= '0;
        end else begin
            state     <= state_nxt;
            rst_cnt   <= rst_cnt_nxt;
            cpu_rst   <= (state_nxt == ST_RESET);
            running   <= (state_nxt == ST_RUN);
            done      <= done_nxt;
            pass      <= pass_nxt;
            timeout   <= timeout_nxt;
            cycle_cnt <= cnt_nxt;
            result    <= result_nxt;
        end
    end

    // Next-state and next-output logic; the store is checked before the watchdog.
    always_comb begin
        state_nxt   = state;
        rst_cnt_nxt = rst_cnt;
        cnt_nxt     = cycle_cnt;
        done_nxt    = done;
        pass_nxt    = pass;
        timeout_nxt = timeout;
        result_nxt  = result;
        case (state)
            ST_RESET: begin
                if (rst_cnt == RST_LAST) begin
                    state_nxt   = ST_RUN;
                    rst_cnt_nxt = '0;
                end else begin
                    rst_cnt_nxt = rst_cnt + RST_W'(1);
                end
            end
            ST_RUN: begin
                if (cycle_cnt != 32'hFFFF_FFFF) begin
                    cnt_nxt = cycle_cnt + 32'd1;
                end
                if (store_hit) begin
                    state_nxt  = ST_DONE;
                    done_nxt   = 1'b1;
                    result_nxt = mon_data;
                    pass_nxt   = (mon_data == PASS_CODE);
                end else if (cycle_cnt == CNT_LAST) begin
                    state_nxt   = ST_TIMEOUT;
                    timeout_nxt = 1'b1;
                    pass_nxt    = 1'b0;
                end
            end
            ST_DONE, ST_TIMEOUT: begin
`ifdef SOPC_RUN_CTRL_RESTART_EN
                if (restart) begin
                    state_nxt   = ST_RESET;
                    rst_cnt_nxt = '0;
                    cnt_nxt     = '0;
                    done_nxt    = 1'b0;
                    pass_nxt    = 1'b0;
                    timeout_nxt = 1'b0;
                    result_nxt  = '0;
                end
`endif
            end
            default: state_nxt = ST_RESET;
        endcase
    end

endmodule

// File: tb/tb_sopc_run_ctrl.sv
// Directed bench for sopc_run_ctrl: table of per-phase vectors plus hand-written
// sequences for the reset pulse width, store-vs-watchdog race and restart.
module tb_sopc_run_ctrl;

    localparam logic [31:0] DONE_A = 32'h0000_FFF0;
    localparam logic [31:0] GOOD   = 32'h600D_600D;
    localparam logic [31:0] BAD    = 32'hBAD0_0001;

    logic        clk = 1'b0;
    logic        rst, mon_we, restart;
    logic [31:0] mon_addr, mon_data;
    logic        cpu_rst, running, done, pass, timeout;
    logic [31:0] cycle_cnt, result;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sopc_run_ctrl dut (
        .clk(clk), .rst(rst), .mon_we(mon_we), .mon_addr(mon_addr),
        .mon_data(mon_data), .restart(restart), .cpu_rst(cpu_rst),
        .running(running), .done(done), .pass(pass), .timeout(timeout),
        .cycle_cnt(cycle_cnt), .result(result)
    );

    typedef struct {
        int          reps;
        logic        rst;
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
        logic        e_cpu_rst;
        logic        e_running;
        logic        e_done;
        logic        e_pass;
        logic        e_timeout;
        logic [31:0] e_cnt;
        logic [31:0] e_result;
    } vec_t;

    vec_t vecs[20];

    function automatic vec_t mk(int reps, logic r, logic we, logic [31:0] a, logic [31:0] d,
                                logic c, logic rn, logic dn, logic ps, logic to,
                                logic [31:0] cnt, logic [31:0] res);
        vec_t v;
        v.reps = reps; v.rst = r; v.we = we; v.addr = a; v.data = d;
        v.e_cpu_rst = c; v.e_running = rn; v.e_done = dn; v.e_pass = ps;
        v.e_timeout = to; v.e_cnt = cnt; v.e_result = res;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock: drive at the falling edge, let the rising edge sample, return at the next falling edge.
    task automatic step(logic r, logic we, logic [31:0] a, logic [31:0] d, logic rs);
        rst = r; mon_we = we; mon_addr = a; mon_data = d; restart = rs;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_all(string tag, logic c, logic rn, logic dn, logic ps, logic to,
                             logic [31:0] cnt, logic [31:0] res);
        check({tag, ".cpu_rst"}, 32'(cpu_rst), 32'(c));
        check({tag, ".running"}, 32'(running), 32'(rn));
        check({tag, ".done"}, 32'(done), 32'(dn));
        check({tag, ".pass"}, 32'(pass), 32'(ps));
        check({tag, ".timeout"}, 32'(timeout), 32'(to));
        check({tag, ".cycle_cnt"}, cycle_cnt, cnt);
        check({tag, ".result"}, result, res);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        vecs[0]  = mk(5,   1, 0, 0, 0,                   1, 0, 0, 0, 0, 0, 0);
        vecs[1]  = mk(9,   0, 0, 0, 0,                   1, 0, 0, 0, 0, 0, 0);
        vecs[2]  = mk(1,   0, 0, 0, 0,                   0, 1, 0, 0, 0, 0, 0);
        vecs[3]  = mk(20,  0, 0, 0, 0,                   0, 1, 0, 0, 0, 20, 0);
        vecs[4]  = mk(1,   0, 1, DONE_A, GOOD,           0, 0, 1, 1, 0, 21, GOOD);
        vecs[5]  = mk(3,   0, 1, DONE_A, BAD,            0, 0, 1, 1, 0, 21, GOOD);
        vecs[6]  = mk(1,   1, 0, 0, 0,                   1, 0, 0, 0, 0, 0, 0);
        vecs[7]  = mk(10,  0, 0, 0, 0,                   0, 1, 0, 0, 0, 0, 0);
        vecs[8]  = mk(5,   0, 1, 32'h0000_FFF4, GOOD,    0, 1, 0, 0, 0, 5, 0);
        vecs[9]  = mk(1,   0, 0, DONE_A, GOOD,           0, 1, 0, 0, 0, 6, 0);
        vecs[10] = mk(1,   0, 1, DONE_A, BAD,            0, 0, 1, 0, 0, 7, BAD);
        vecs[11] = mk(1,   1, 0, 0, 0,                   1, 0, 0, 0, 0, 0, 0);
        vecs[12] = mk(10,  0, 0, 0, 0,                   0, 1, 0, 0, 0, 0, 0);
        vecs[13] = mk(50,  0, 0, 0, 0,                   0, 1, 0, 0, 0, 50, 0);
        vecs[14] = mk(1,   1, 0, 0, 0,                   1, 0, 0, 0, 0, 0, 0);
        vecs[15] = mk(9,   0, 0, 0, 0,                   1, 0, 0, 0, 0, 0, 0);
        vecs[16] = mk(1,   0, 0, 0, 0,                   0, 1, 0, 0, 0, 0, 0);
        vecs[17] = mk(999, 0, 0, 0, 0,                   0, 1, 0, 0, 0, 999, 0);
        vecs[18] = mk(1,   0, 0, 0, 0,                   0, 0, 0, 0, 1, 1000, 0);
        vecs[19] = mk(5,   0, 1, DONE_A, GOOD,           0, 0, 0, 0, 1, 1000, 0);

        rst = 1'b1; mon_we = 1'b0; mon_addr = '0; mon_data = '0; restart = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 20; i++) begin
            for (int k = 0; k < vecs[i].reps; k++)
                step(vecs[i].rst, vecs[i].we, vecs[i].addr, vecs[i].data, 1'b0);
            check_all($sformatf("v%0d", i), vecs[i].e_cpu_rst, vecs[i].e_running,
                      vecs[i].e_done, vecs[i].e_pass, vecs[i].e_timeout,
                      vecs[i].e_cnt, vecs[i].e_result);
        end

        // cpu_rst width measured cycle by cycle after rst falls
        for (int k = 0; k < 3; k++) step(1, 0, 0, 0, 0);
        for (int k = 1; k <= 10; k++) begin
            step(0, 0, 0, 0, 0);
            check($sformatf("pulse%0d.cpu_rst", k), 32'(cpu_rst), (k < 10) ? 32'd1 : 32'd0);
            check($sformatf("pulse%0d.running", k), 32'(running), (k < 10) ? 32'd0 : 32'd1);
        end

        // store in the last watchdog cycle wins over timeout
        for (int k = 0; k < 999; k++) step(0, 0, 0, 0, 0);
        check("race.pre_cnt", cycle_cnt, 32'd999);
        step(0, 1, DONE_A, GOOD, 0);
        check_all("race", 0, 0, 1, 1, 0, 1000, GOOD);

        // restart in DONE
        step(0, 0, 0, 0, 1);
`ifdef SOPC_RUN_CTRL_RESTART_EN
        check_all("restart", 1, 0, 0, 0, 0, 0, 0);
        for (int k = 1; k < 10; k++) step(0, 0, 0, 0, 0);
        check("restart.still_rst", 32'(cpu_rst), 32'd1);
        step(0, 0, 0, 0, 0);
        check_all("restart.run", 0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        check_all("restart.in_run", 0, 1, 0, 0, 0, 1, 0);
`else
        check_all("restart_ign", 0, 0, 1, 1, 0, 1000, GOOD);
        step(0, 0, 0, 0, 1);
        check_all("restart_ign2", 0, 0, 1, 1, 0, 1000, GOOD);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
